dadda_mul_arbiter: RTL and testbench
====================================

Name: dadda_mul_arbiter

Overview:
- Shares one combinational 8x8 Dadda multiplier core (dada88) between NREQ requesters.
- Round-robin arbitration picks at most one request per cycle. Operands are registered before the core and the product is registered after it, so the block is a 2-stage pipeline.
- A single response channel returns each product with the requester index.
- Sits between the operand-issuing units and the shared multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  operand B; same packing as req_a.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts product.
- resp_id  output  IDW  index of the requester that owns resp_prod.
- resp_prod  output  16  unsigned product, taken unmodified from the core's op port.

Behaviour:
- Reset state:
  - s1_valid=0, resp_valid=0, resp_prod=0, resp_id=0, RR pointer ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards all in-flight operations; no response is produced for them.
- Stall logic:
  - adv2 = !resp_valid | resp_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration:
  - Runs only when adv1=1. Scans req_valid starting at index ptr, ascending, wrapping at NREQ-1 to 0.
  - The first asserted index i gets req_ready[i]=1; all others get 0.
  - req_ready is combinational from req_valid, ptr and the stall state.
  - A handshake completes when req_valid[i] & req_ready[i] are both high in the same cycle.
  - On a grant: ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Stage 1, on adv1:
  - s1_valid <= grant_any.
  - s1_a, s1_b, s1_id capture the granted operands.
  - When adv1=0, stage 1 holds.
- Core: a combinational dada88 instance is fed s1_a and s1_b.
- Stage 2, on adv2:
  - resp_valid <= s1_valid.
  - resp_prod <= core product.
  - resp_id <= s1_id.
  - When adv2=0, all resp_* outputs hold stable until accepted.
- Latency and throughput:
  - A request accepted in cycle T produces resp_valid in cycle T+2 if resp_ready was high.
  - Throughput is 1 product per cycle when resp_ready is held high.
- Ordering: responses leave in grant order; there is no reordering.
- Fairness: a continuously asserting requester is granted within NREQ grants.
- Backpressure:
  - With resp_ready low, at most 2 operations are held (stage 1 and stage 2).
  - After that, all req_ready stay 0.
  - req_a and req_b need only be stable in the handshake cycle.
- Simultaneous events:
  - When resp_ready rises while s1 and resp are both full, stage 1 moves to stage 2 and a new grant is issued in the same cycle.
  - A requester deasserting req_valid before it is granted is simply skipped.
- Arithmetic: unsigned 8x8 -> 16; no overflow is possible.
- The core's partial-product bus (re) is left unconnected.

Optional Feature:
- Macro name: DADDA_ARB_STATS_EN.
- When defined, the block adds these outputs:
  - stat_grants, NREQ*16 bits: per-requester grant counters.
  - stat_stall, 16 bits: counts cycles with resp_valid & !resp_ready.
- Counter behaviour:
  - All counters reset to 0 on rst.
  - All counters saturate at 16'hFFFF; they do not wrap.
  - stat_clr, an input, clears all counters synchronously. When stat_clr coincides with a counted event, the clear wins and the counter reads 0.
- When undefined, these ports and their logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: rst for 2 cycles, then req 0 with a=8'h0F, b=8'h11; resp_ready=1.
  - Expect: resp_valid exactly 2 cycles after the handshake, resp_prod=16'h00FF, resp_id=0.
- All requesters simultaneous:
  - Stimulus: NREQ=4, all req_valid held high; operands a=i+1, b=8'hFF for requester i.
  - Expect: grants in order 0,1,2,3,0,...; products 16'h00FF, 16'h01FE, 16'h02FD, 16'h03FC; one response per cycle.
- Backpressure:
  - Stimulus: resp_ready=0 with req 2 streaming.
  - Expect: exactly 2 accepts, then req_ready=0; resp_prod and resp_id stable while stalled.
  - Stimulus: raise resp_ready.
  - Expect: both responses drain in order with no loss or duplication.
- Fairness wrap:
  - Stimulus: only req 3 and req 0 active.
  - Expect: grants alternate 3,0,3,0.
  - Stimulus: a=b=8'hFF.
  - Expect: resp_prod=16'hFE01.
- Reset mid-flight:
  - Stimulus: assert rst while stage 1 and stage 2 are both full.
  - Expect: next cycle resp_valid=0, no stale response, ptr=0 so the next grant goes to the lowest active index.
- Stats, with DADDA_ARB_STATS_EN:
  - Stimulus: 3 grants to req 1 and 5 stall cycles.
  - Expect: stat_grants[1]=3, stat_stall=5.
  - Stimulus: pulse stat_clr.
  - Expect: all counters read 0.

Source files
------------

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin front end sharing one combinational 8x8
// Dadda multiplier (dada88) between NREQ requesters.  Operands are
// registered ahead of the core and the product is registered after it,
// which gives a 2-stage pipeline with a single valid/ready response channel.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid[NREQ]   per-requester request valid
//   req_ready[NREQ]   per-requester accept (one-hot or zero, combinational)
//   req_a/req_b       8-bit operands, requester i on bits [8i+7:8i]
//   resp_valid        product valid
//   resp_ready        consumer accepts product
//   resp_id[IDW]      index of the requester owning resp_prod
//   resp_prod[16]     unsigned product
// Optional (macro DADDA_ARB_STATS_EN):
//   stat_clr          synchronous clear of all counters (wins over counting)
//   stat_grants       NREQ x 16-bit saturating grant counters
//   stat_stall        16-bit saturating count of resp_valid & !resp_ready cycles

// dada88: combinational unsigned 8x8 Dadda multiplier.
//   a, b  operands
//   op    16-bit product
//   re    64-bit partial-product bus, re[8i+j] = a[j] & b[i]
module dada88 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] op,
  output logic [63:0] re
);

  // Column-wise Dadda reduction with stage heights 6,4,3,2 followed by a
  // final carry-propagate add of the two remaining rows.  Column heights
  // depend only on the structure, so every loop collapses to fixed wiring.
  // Arrays carry one spare column so carries out of column 15 have a home.
  function automatic logic [15:0] dadda_reduce(input logic [7:0] x,
                                               input logic [7:0] y);
    logic        col [17][16];
    logic        nxt [17][16];
    int unsigned h   [17];
    int unsigned nh  [17];
    int unsigned tgt;
    int unsigned tot;
    int unsigned idx;
    logic        s0, s1, s2;
    logic [15:0] row0, row1;

    for (int unsigned c = 0; c < 17; c++) begin
      h[c] = 0;
      for (int unsigned r = 0; r < 16; r++) col[c][r] = 1'b0;
    end

    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        col[i+j][h[i+j]] = x[j] & y[i];
        h[i+j]           = h[i+j] + 1;
      end
    end

    for (int unsigned st = 0; st < 4; st++) begin
      case (st)
        0:       tgt = 6;
        1:       tgt = 4;
        2:       tgt = 3;
        default: tgt = 2;
      endcase

      for (int unsigned c = 0; c < 17; c++) begin
        nh[c] = 0;
        for (int unsigned r = 0; r < 16; r++) nxt[c][r] = 1'b0;
      end

      for (int unsigned c = 0; c < 16; c++) begin
        // Output height counts carries already pushed in from column c-1.
        tot = h[c] + nh[c];
        idx = 0;
        for (int unsigned n = 0; n < 8; n++) begin
          if (tot > tgt + 1) begin
            s0 = col[c][idx];
            s1 = col[c][idx+1];
            s2 = col[c][idx+2];
            nxt[c][nh[c]]     = s0 ^ s1 ^ s2;
            nh[c]             = nh[c] + 1;
            nxt[c+1][nh[c+1]] = (s0 & s1) | (s0 & s2) | (s1 & s2);
            nh[c+1]           = nh[c+1] + 1;
            idx               = idx + 3;
            tot               = tot - 2;
          end else if (tot > tgt) begin
            s0 = col[c][idx];
            s1 = col[c][idx+1];
            nxt[c][nh[c]]     = s0 ^ s1;
            nh[c]             = nh[c] + 1;
            nxt[c+1][nh[c+1]] = s0 & s1;
            nh[c+1]           = nh[c+1] + 1;
            idx               = idx + 2;
            tot               = tot - 1;
          end
        end
        for (int unsigned r = 0; r < 16; r++) begin
          if (r >= idx && r < h[c]) begin
            nxt[c][nh[c]] = col[c][r];
            nh[c]         = nh[c] + 1;
          end
        end
      end

      col = nxt;
      h   = nh;
    end

    for (int unsigned c = 0; c < 16; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    return row0 + row1;
  endfunction

  always_comb begin
    re = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        re[8*i+j] = a[j] & b[i];
      end
    end
    op = dadda_reduce(a, b);
  end

endmodule

module dadda_mul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       resp_prod
`ifdef DADDA_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [16*NREQ-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  logic                         s1_valid;
  logic [7:0]                   s1_a;
  logic [7:0]                   s1_b;
  logic [IDW-1:0]               s1_id;
  logic [IDW-1:0]               ptr;
  logic [IDW-1:0]               ptr_next;
  logic [IDW-1:0]               grant_idx;
  logic                         grant_any;
  logic                         adv1;
  logic                         adv2;
  logic [7:0]                   sel_a;
  logic [7:0]                   sel_b;
  logic [15:0]                  core_prod;
  // Operand views padded to 2**IDW lanes so grant_idx indexes them exactly.
  logic [(1<<IDW)-1:0][7:0]     a_vec;
  logic [(1<<IDW)-1:0][7:0]     b_vec;

  // Stall chain and round-robin scan starting at ptr.
  always_comb begin
    adv2      = !resp_valid || resp_ready;
    adv1      = !s1_valid || adv2;
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    ptr_next  = ptr;
    if (!rst && adv1) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!grant_any && req_valid[i] && ((32'(ptr) + off) % NREQ == i)) begin
            req_ready[i] = 1'b1;
            grant_any    = 1'b1;
            grant_idx    = IDW'(i);
            ptr_next     = IDW'((i + 1) % NREQ);
          end
        end
      end
    end
  end

  always_comb begin
    a_vec             = '0;
    b_vec             = '0;
    a_vec[NREQ-1:0]   = req_a;
    b_vec[NREQ-1:0]   = req_b;
    sel_a             = a_vec[grant_idx];
    sel_b             = b_vec[grant_idx];
  end

  dada88 u_core (
    .a  (s1_a),
    .b  (s1_b),
    .op (core_prod),
    .re ()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      ptr        <= '0;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      resp_id    <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= grant_any;
        if (grant_any) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= grant_idx;
          ptr   <= ptr_next;
        end
      end
      if (adv2) begin
        resp_valid <= s1_valid;
        resp_prod  <= core_prod;
        resp_id    <= s1_id;
      end
    end
  end

`ifdef DADDA_ARB_STATS_EN
  logic [NREQ-1:0][15:0] grant_cnt;
  logic [15:0]           stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[i] != '1) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
      if (resp_valid && !resp_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign stat_grants = grant_cnt;
  assign stat_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Testbench for dadda_mul_arbiter (NREQ=4, IDW=2).  A transaction-level
// model (two pipeline slots, round-robin pointer, plain a*b products) is
// compared against the DUT every cycle; directed scenarios add literal
// expectations.  Define DADDA_ARB_STATS_EN to include the counter checks.
module tb_dadda_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_prod;
`ifdef DADDA_ARB_STATS_EN
  logic               stat_clr;
  logic [16*NREQ-1:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  dadda_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod)
`ifdef DADDA_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int id; int prod; } rsp_t;
  rsp_t log_q[$];
  bit   m_out_v = 1'b0;
  bit   m_mid_v = 1'b0;
  int   m_out_id, m_out_p, m_mid_id, m_mid_p;
  int   m_ptr = 0;
  int   hs_total = 0;
`ifdef DADDA_ARB_STATS_EN
  int   m_gcnt[NREQ];
  int   m_stall = 0;
`endif

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int g;
    int j;
    bit can_take;
    bit out_adv;
    exp_ready = '0;
    g = -1;
    can_take = !m_mid_v || !m_out_v || resp_ready;
    if (!rst && can_take) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) begin
          g = j;
          exp_ready[j] = 1'b1;
        end
      end
    end

    if (checking) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(m_out_v));
      if (m_out_v) begin
        chk("resp_id", 32'(resp_id), m_out_id);
        chk("resp_prod", 32'(resp_prod), m_out_p);
      end
`ifdef DADDA_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("stat_grants", 32'(stat_grants[16*i +: 16]), m_gcnt[i]);
      chk("stat_stall", 32'(stat_stall), m_stall);
`endif
    end

    if (rst) begin
      m_out_v = 1'b0;
      m_mid_v = 1'b0;
      m_ptr   = 0;
`ifdef DADDA_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
      m_stall = 0;
`endif
    end else begin
`ifdef DADDA_ARB_STATS_EN
      if (g >= 0 && m_gcnt[g] < 65535) m_gcnt[g]++;
      if (m_out_v && !resp_ready && m_stall < 65535) m_stall++;
      if (stat_clr) begin
        for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
        m_stall = 0;
      end
`endif
      if (m_out_v && resp_ready) log_q.push_back('{m_out_id, m_out_p});
      out_adv = !m_out_v || resp_ready;
      if (out_adv) begin
        m_out_v  = m_mid_v;
        m_out_id = m_mid_id;
        m_out_p  = m_mid_p;
      end
      if (can_take) begin
        m_mid_v = (g >= 0);
        if (g >= 0) begin
          m_mid_id = g;
          m_mid_p  = int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8]);
          m_ptr    = (g + 1) % NREQ;
          hs_total++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int base;
  int hs_base;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
`ifdef DADDA_ARB_STATS_EN
    stat_clr   = 1'b0;
`endif
    step();
    checking = 1'b1;
    step();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_prod", 32'(resp_prod), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;

    // Single request: 0x0F * 0x11 from requester 0
    req_valid = 4'b0001;
    req_a     = 32'h0000_000F;
    req_b     = 32'h0000_0011;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_lat1_valid", 32'(resp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_valid", 32'(resp_valid), 32'd1);
    chk("t1_prod", 32'(resp_prod), 32'h00FF);
    chk("t1_id", 32'(resp_id), 32'd0);
    step();

    // All requesters streaming, a=i+1, b=0xFF
    do_reset();
    base      = log_q.size();
    req_valid = 4'b1111;
    req_a     = 32'h0403_0201;
    req_b     = 32'hFFFF_FFFF;
    repeat (12) step();
    req_valid = '0;
    repeat (3) step();
    chk("t2_count", 32'(log_q.size() - base), 32'd12);
    if (log_q.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_id", 32'(log_q[base+k].id), 32'(k % 4));
        chk("t2_prod", 32'(log_q[base+k].prod), 32'((k % 4 + 1) * 255));
      end
    end

    // Backpressure: requester 2 streaming with resp_ready low
    do_reset();
    hs_base    = hs_total;
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    req_a      = 32'h000A_0000;
    req_b      = 32'h0003_0000;
    step();
    req_a = 32'h0014_0000;
    step();
    req_a = 32'h001E_0000;
    repeat (4) step();
    @(negedge clk);
    chk("t3_ready_blocked", 32'(req_ready), 32'd0);
    chk("t3_hold_id", 32'(resp_id), 32'd2);
    chk("t3_hold_prod", 32'(resp_prod), 32'h001E);
    step();
    chk("t3_accepts", 32'(hs_total - hs_base), 32'd2);
    base       = log_q.size();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (3) step();
    chk("t3_drain_count", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      chk("t3_first_prod", 32'(log_q[base].prod), 32'h001E);
      chk("t3_second_prod", 32'(log_q[base+1].prod), 32'h003C);
      chk("t3_second_id", 32'(log_q[base+1].id), 32'd2);
    end

    // Fairness wrap: move ptr to 3, then requesters 3 and 0 contend
    do_reset();
    base      = log_q.size();
    req_valid = 4'b0100;
    req_a     = 32'h0001_0000;
    req_b     = 32'h0001_0000;
    step();
    req_valid = 4'b1001;
    req_a     = 32'hFF00_00FF;
    req_b     = 32'hFF00_00FF;
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();
    chk("t4_count", 32'(log_q.size() - base), 32'd5);
    if (log_q.size() >= base + 5) begin
      chk("t4_lead_id", 32'(log_q[base].id), 32'd2);
      for (int k = 1; k < 5; k++) begin
        chk("t4_id", 32'(log_q[base+k].id), (k % 2 == 1) ? 32'd3 : 32'd0);
        chk("t4_prod", 32'(log_q[base+k].prod), 32'hFE01);
      end
    end

    // Reset with both stages full
    do_reset();
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    req_a      = 32'h0000_0500;
    req_b      = 32'h0000_0700;
    step();
    step();
    rst  = 1'b1;
    base = log_q.size();
    step();
    rst        = 1'b0;
    req_valid  = 4'b1010;
    req_a      = 32'h0200_0900;
    req_b      = 32'h0700_0700;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_flushed", 32'(resp_valid), 32'd0);
    chk("t5_first_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    repeat (3) step();
    chk("t5_count", 32'(log_q.size() - base), 32'd1);
    if (log_q.size() >= base + 1) begin
      chk("t5_id", 32'(log_q[base].id), 32'd1);
      chk("t5_prod", 32'(log_q[base].prod), 32'h003F);
    end

`ifdef DADDA_ARB_STATS_EN
    // Counters: 3 grants to requester 1, one to requester 0, 5 stall cycles
    do_reset();
    req_valid = 4'b0010;
    req_a     = 32'h0000_0101;
    req_b     = 32'h0000_0101;
    repeat (3) step();
    req_valid = '0;
    repeat (3) step();
    resp_ready = 1'b0;
    req_valid  = 4'b0001;
    step();
    req_valid = '0;
    step();
    repeat (5) step();
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t6_grants1", 32'(stat_grants[31:16]), 32'd3);
    chk("t6_grants0", 32'(stat_grants[15:0]), 32'd1);
    chk("t6_stall", 32'(stat_stall), 32'd5);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_lo", stat_grants[31:0], 32'd0);
    chk("t6_clr_hi", stat_grants[63:32], 32'd0);
    chk("t6_clr_stall", 32'(stat_stall), 32'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
